// File: rtl/ibex_ex_iter_muldiv.sv
// Iterative multiply/divide unit: shift-add MUL/MULHU, restoring DIVU/REMU.
// The divider datapath exists only when IBEX_EX_ITER_DIV_EN is defined; otherwise DIVU/REMU report err_o.
module ibex_ex_iter_muldiv #(
  parameter int unsigned Width     = 32,
  parameter bit          EarlyTerm = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             kill_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [Width-1:0] result_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(Width);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_reg, state_next;
  logic               op_hi_reg, op_hi_next;
  logic [CntW-1:0]    cnt_reg, cnt_next;
  logic [2*Width-1:0] mcand_reg, mcand_next;
  logic [2*Width-1:0] prod_reg, prod_next;
  logic [Width-1:0]   mplier_reg, mplier_next;
  logic [Width-1:0]   result_reg, result_next;

  logic               accept;
  logic [2*Width-1:0] prod_add;
  logic [Width-1:0]   mplier_shift;
  logic               mul_last;
  logic [Width-1:0]   mul_res;
  logic               iter_last;

  assign accept = (state_reg == IDLE) && req_valid_i && !kill_i;

  // The multiplicand is pre-shifted each step, so the product is aligned after every iteration
  // and early termination needs no final correction shift.
  assign prod_add     = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;
  assign mplier_shift = mplier_reg >> 1;
  assign iter_last    = (cnt_reg == CntW'(Width - 1));
  assign mul_last     = iter_last || (EarlyTerm && (mplier_shift == '0));
  assign mul_res      = op_hi_reg ? prod_add[2*Width-1:Width] : prod_add[Width-1:0];

`ifdef IBEX_EX_ITER_DIV_EN
  logic [Width-1:0] rem_reg, rem_next;
  logic [Width-1:0] quo_reg, quo_next;
  logic [Width-1:0] divisor_reg, divisor_next;
  logic [Width:0]   div_shift;
  logic [Width:0]   div_diff;
  logic             div_ge;
  logic [Width-1:0] rem_new;
  logic [Width-1:0] quo_new;
  logic [Width-1:0] div_res;

  // Partial remainder always stays below the divisor, so bit Width of the difference is its sign.
  assign div_shift = {rem_reg, quo_reg[Width-1]};
  assign div_diff  = div_shift - {1'b0, divisor_reg};
  assign div_ge    = !div_diff[Width];
  assign rem_new   = div_ge ? div_diff[Width-1:0] : div_shift[Width-1:0];
  assign quo_new   = {quo_reg[Width-2:0], div_ge};
  assign div_res   = op_hi_reg ? rem_new : quo_new;
  assign err_o     = 1'b0;
`else
  logic err_reg, err_next;
  assign err_o = err_reg;
`endif

  always_comb begin
    state_next  = state_reg;
    op_hi_next  = op_hi_reg;
    cnt_next    = cnt_reg;
    mcand_next  = mcand_reg;
    prod_next   = prod_reg;
    mplier_next = mplier_reg;
    result_next = result_reg;
`ifdef IBEX_EX_ITER_DIV_EN
    rem_next     = rem_reg;
    quo_next     = quo_reg;
    divisor_next = divisor_reg;
`else
    err_next     = err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_hi_next = op_i[0];
          cnt_next   = '0;
          if (!op_i[1]) begin
            state_next  = MUL;
            mcand_next  = {{Width{1'b0}}, operand_a_i};
            mplier_next = operand_b_i;
            prod_next   = '0;
`ifndef IBEX_EX_ITER_DIV_EN
            err_next    = 1'b0;
`endif
          end else begin
`ifdef IBEX_EX_ITER_DIV_EN
            if (operand_b_i == '0) begin
              state_next  = DONE;
              result_next = op_i[0] ? operand_a_i : {Width{1'b1}};
            end else begin
              state_next   = DIV;
              rem_next     = '0;
              quo_next     = operand_a_i;
              divisor_next = operand_b_i;
            end
`else
            state_next  = DONE;
            result_next = '0;
            err_next    = 1'b1;
`endif
          end
        end
      end

      MUL: begin
        prod_next   = prod_add;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_shift;
        cnt_next    = cnt_reg + 1'b1;
        if (mul_last) begin
          state_next  = DONE;
          result_next = mul_res;
        end
      end

      DIV: begin
`ifdef IBEX_EX_ITER_DIV_EN
        rem_next = rem_new;
        quo_next = quo_new;
        cnt_next = cnt_reg + 1'b1;
        if (iter_last) begin
          state_next  = DONE;
          result_next = div_res;
        end
`else
        state_next = IDLE;
`endif
      end

      DONE: begin
        if (res_ready_i) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Abort wins over everything, including an accept or a result handshake.
    if (kill_i) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      op_hi_reg    <= 1'b0;
      cnt_reg      <= '0;
      mcand_reg    <= '0;
      prod_reg     <= '0;
      mplier_reg   <= '0;
      result_reg   <= '0;
`ifdef IBEX_EX_ITER_DIV_EN
      rem_reg      <= '0;
      quo_reg      <= '0;
      divisor_reg  <= '0;
`else
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      op_hi_reg    <= op_hi_next;
      cnt_reg      <= cnt_next;
      mcand_reg    <= mcand_next;
      prod_reg     <= prod_next;
      mplier_reg   <= mplier_next;
      result_reg   <= result_next;
`ifdef IBEX_EX_ITER_DIV_EN
      rem_reg      <= rem_next;
      quo_reg      <= quo_next;
      divisor_reg  <= divisor_next;
`else
      err_reg      <= err_next;
`endif
    end
  end

  assign req_ready_o = (state_reg == IDLE);
  assign res_valid_o = (state_reg == DONE);
  assign busy_o      = (state_reg == MUL) || (state_reg == DIV);
  assign result_o    = result_reg;

endmodule

// File: doc/ibex_ex_iter_muldiv.md
IBEX_EX_ITER_MULDIV -- requirements
Module: ibex_ex_iter_muldiv

Interface
REQ-001 SHALL have parameter Width, default 32: operand and result width in bits, minimum 8.
REQ-002 SHALL have parameter EarlyTerm, default 1: when 1, a multiply ends as soon as its remaining multiplier bits are zero.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i, input, 1 bit: a request is presented.
REQ-006 SHALL have port req_ready_o, output, 1 bit: the unit can accept a request.
REQ-007 SHALL have port op_i, input, 2 bits: 00 MUL (low half), 01 MULHU (high half, unsigned), 10 DIVU, 11 REMU.
REQ-008 SHALL have ports operand_a_i and operand_b_i, input, Width bits each: unsigned operands.
REQ-009 SHALL have port kill_i, input, 1 bit: abort the operation in flight.
REQ-010 SHALL have port res_valid_o, output, 1 bit: result_o and err_o are valid.
REQ-011 SHALL have port res_ready_i, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port result_o, output, Width bits: operation result.
REQ-013 SHALL have port err_o, output, 1 bit: the op is unsupported in this build.
REQ-014 SHALL have port busy_o, output, 1 bit: the FSM is in MUL or DIV.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV and DONE; req_ready_o = (state==IDLE), res_valid_o = (state==DONE), busy_o = (state==MUL or DIV).
REQ-016 SHALL accept a request in cycle T when req_valid_i and req_ready_o are both 1 and kill_i=0, latching op and operands.
REQ-017 SHALL take MUL/MULHU to state MUL at T+1 and run one shift-add iteration per cycle into a 2*Width-bit product register.
REQ-018 SHALL, with EarlyTerm=0, run exactly Width iterations (T+1..T+Width) and enter DONE at T+Width+1.
REQ-019 SHALL, with EarlyTerm=1, enter DONE the cycle after any iteration that leaves the remaining multiplier at zero, with the product correctly aligned (operand_b_i=0 gives DONE at T+2, result 0).
REQ-020 SHALL take DIVU/REMU with a nonzero divisor to state DIV at T+1, run Width restoring-division iterations (T+1..T+Width), and enter DONE at T+Width+1.
REQ-021 SHALL, for DIVU/REMU with divisor 0, enter DONE at T+1 with quotient all-ones and remainder = operand_a_i.
REQ-022 SHALL make result_o equal to product[Width-1:0] for MUL, product[2*Width-1:Width] for MULHU, the quotient for DIVU and the remainder for REMU.
REQ-023 SHALL hold result_o and err_o stable while in DONE, and return to IDLE the cycle after res_ready_i=1; a new request is never accepted in the same cycle.
REQ-024 SHALL, on kill_i=1 in any state, go to IDLE next cycle with no res_valid_o; kill_i has priority over a simultaneous accept or res_ready_i.
REQ-025 SHALL ignore req_valid_i while not in IDLE, and SHALL ignore op/operand changes after acceptance.

Reset
REQ-026 SHALL, while rst_ni=0, asynchronously force state IDLE and clear all datapath registers.
REQ-027 SHALL hold reset output values req_ready_o=1, res_valid_o=0, busy_o=0, err_o=0, result_o=0.
REQ-028 SHALL, if reset asserts mid-operation, discard the operation and never emit its result.

Configuration
REQ-029 SHALL compile the DIV datapath only when macro IBEX_EX_ITER_DIV_EN is defined; with it defined, err_o is constantly 0.
REQ-030 SHALL, without IBEX_EX_ITER_DIV_EN, accept DIVU/REMU and enter DONE at T+1 with result_o=0 and err_o=1; MUL/MULHU are unaffected.

Verification (Width=32)
REQ-031 SHALL cover MUL with a=7, b=6, EarlyTerm=0 -> res_valid_o at T+33 with result_o=42 and err_o=0.
REQ-032 SHALL cover MULHU with a=b=0xFFFFFFFF -> result_o=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-033 SHALL cover DIVU 100/7 -> result_o=14 at T+33, and REMU 100/7 -> result_o=2 (both with the macro defined).
REQ-034 SHALL cover DIVU 5/0 -> result_o=0xFFFFFFFF at T+1, and REMU 5/0 -> result_o=5 at T+1.
REQ-035 SHALL cover kill_i at T+5 of a MUL -> res_valid_o never rises and req_ready_o=1 at T+6; reset asserted at T+10 of a DIVU -> same outcome.
REQ-036 SHALL cover res_ready_i held 0 for 10 cycles in DONE -> result_o stable and req_ready_o=0; macro undefined with DIVU -> err_o=1 and result_o=0 at T+1.
